alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Parametrised successor to the combinational ALU decode stage: decodes alu_op/funct3/funct7, then executes the operation with a valid/ready handshake.
- Adds SRA, SLTU, SLTI-class I-type decode, illegal-encoding detection, and an optional iterative MUL/DIVU/REMU engine.
- Sits between the register-read stage and writeback.
- Stalls the core via in_ready while a multi-cycle operation runs.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from operand b.

Ports:
- clk  input  1  rising-edge clock; the block uses one clock only.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (state IDLE).
- alu_op  input  2  00 R-type, 01 load/store address, 10 branch compare, 11 I-type ALU.
- funct3  input  3  instruction bits 14:12.
- funct7  input  7  instruction bits 31:25.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value or immediate.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0, qualified by out_valid.
- illegal  output  1  unsupported encoding; result forced to 0.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0.
- Reset has priority over every event and aborts an in-flight iteration with no output.
- Accept: in_valid & in_ready on a rising edge latches operands and the decoded select (4-bit).
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE when a single-cycle op is accepted; out_valid rises the next cycle (latency 1).
  - IDLE -> BUSY when an iterative op is accepted.
  - BUSY: iteration counter runs 0..XLEN-1. At the last count -> DONE; out_valid at accept+XLEN+1.
  - DONE: hold result, zero, illegal stable until out_valid & out_ready, then -> IDLE.
  - No new accept is possible in the same cycle as the out handshake, because in_ready=0 in DONE.
- Decode for alu_op=00 ({funct7,funct3}):
  - 0000000 with f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 0100000 with f3 000 SUB, 101 SRA.
  - Any other combination is illegal.
- alu_op=01: ADD regardless of funct fields.
- alu_op=10 (branch):
  - f3 000/001 SUB; 100/101 SLT; 110/111 SLTU.
  - f3 010/011 illegal.
- alu_op=11 (I-type):
  - f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; funct7 is ignored for these.
  - f3 001 SLL only if funct7=0000000.
  - f3 101 SRL if funct7=0000000, SRA if funct7=0100000.
  - Any other shift funct7 is illegal.
- Arithmetic rules:
  - All results are modulo 2^XLEN.
  - Shifts use op_b[SHAMT_W-1:0].
  - SLT/SLTU return 0 or 1, zero-extended.
- Illegal encodings complete in 1 cycle with result=0, zero=1, illegal=1.

Optional Feature:
- Macro ALU_EXEC_MULDIV_EN.
- Defined: alu_op=00 with funct7=0000001 decodes
  - f3 000 MUL: shift-add, low XLEN bits of the product.
  - f3 101 DIVU: restoring division, quotient.
  - f3 111 REMU: restoring division, remainder.
  - Each takes the BUSY path (XLEN iterations).
  - Divisor 0: bypass BUSY, 1-cycle result; DIVU gives all ones, REMU gives op_a.
  - Other f3 values under funct7=0000001 are illegal.
- Undefined: funct7=0000001 is always illegal; the BUSY state and counter are absent; every op has latency 1.

Decomposition:
- Package alu_exec_pkg holds:
  - 4-bit select codes SEL_ADD..SEL_REMU;
  - alu_op codes ALUOP_R, ALUOP_MEM, ALUOP_BR, ALUOP_I;
  - the state enum;
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
- Sub-module alu_iter_muldiv (built only under the macro) holds:
  - the accumulator/remainder registers and the iteration counter;
  - handshake start/done to the parent FSM.

Test Plan (XLEN=32):
- Reset held for 3 cycles mid-DIVU (iteration 10) -> next cycle IDLE, in_ready=1, out_valid=0; no stale result ever appears.
- R-type SUB with a=5, b=7 -> result 0xFFFFFFFE, zero=0, out_valid 1 cycle after accept. SRA with a=0x80000000, b=0x24 -> 0xF8000000 (shift 4).
- Branch f3=110 with a=0xFFFFFFFF, b=1 -> result 0 (SLTU), zero=1. f3=100 with the same operands -> result 1 (SLT).
- I-type f3=001 with funct7=0100000 -> illegal=1, result=0. alu_op=01 with a=0x1000, b=0xFFFFFFFC -> 0x00000FFC.
- Backpressure: out_ready=0 for 5 cycles after the result -> result stable, in_ready=0 throughout. out_ready pulse -> IDLE the next cycle.
- With ALU_EXEC_MULDIV_EN defined:
  - MUL 0x12345678×0x10 -> 0x23456780, out_valid at accept+33.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU x/0 -> 0xFFFFFFFF in 1 cycle.
- Without the macro, the same MUL encoding -> illegal=1.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types, encodings and decode helper for the sequential ALU execute stage.
// ALU_EXEC_MULDIV_EN adds the MUL/DIVU/REMU decode and the BUSY state.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    SEL_ADD  = 4'd0,
    SEL_SUB  = 4'd1,
    SEL_SLL  = 4'd2,
    SEL_SLT  = 4'd3,
    SEL_SLTU = 4'd4,
    SEL_XOR  = 4'd5,
    SEL_SRL  = 4'd6,
    SEL_SRA  = 4'd7,
    SEL_OR   = 4'd8,
    SEL_AND  = 4'd9,
    SEL_MUL  = 4'd10,
    SEL_DIVU = 4'd11,
    SEL_REMU = 4'd12
  } sel_t;

  localparam logic [1:0] ALUOP_R   = 2'b00;
  localparam logic [1:0] ALUOP_MEM = 2'b01;
  localparam logic [1:0] ALUOP_BR  = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef ALU_EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

  typedef struct packed {
    sel_t sel;
    logic illegal;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] alu_op,
                                  input logic [2:0] funct3,
                                  input logic [6:0] funct7);
    dec_t d;
    d.sel     = SEL_ADD;
    d.illegal = 1'b0;
    case (alu_op)
      ALUOP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  d.sel = SEL_ADD;
            3'b001:  d.sel = SEL_SLL;
            3'b010:  d.sel = SEL_SLT;
            3'b011:  d.sel = SEL_SLTU;
            3'b100:  d.sel = SEL_XOR;
            3'b101:  d.sel = SEL_SRL;
            3'b110:  d.sel = SEL_OR;
            default: d.sel = SEL_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          d.sel = SEL_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          d.sel = SEL_SRA;
`ifdef ALU_EXEC_MULDIV_EN
        end else if (funct7 == F7_MULDIV && funct3 == 3'b000) begin
          d.sel = SEL_MUL;
        end else if (funct7 == F7_MULDIV && funct3 == 3'b101) begin
          d.sel = SEL_DIVU;
        end else if (funct7 == F7_MULDIV && funct3 == 3'b111) begin
          d.sel = SEL_REMU;
`endif
        end else begin
          d.illegal = 1'b1;
        end
      end
      ALUOP_MEM: d.sel = SEL_ADD;
      ALUOP_BR: begin
        case (funct3)
          3'b000, 3'b001: d.sel = SEL_SUB;
          3'b100, 3'b101: d.sel = SEL_SLT;
          3'b110, 3'b111: d.sel = SEL_SLTU;
          default:        d.illegal = 1'b1;
        endcase
      end
      default: begin
        case (funct3)
          3'b000: d.sel = SEL_ADD;
          3'b010: d.sel = SEL_SLT;
          3'b011: d.sel = SEL_SLTU;
          3'b100: d.sel = SEL_XOR;
          3'b110: d.sel = SEL_OR;
          3'b111: d.sel = SEL_AND;
          3'b001: begin
            if (funct7 == F7_BASE) d.sel = SEL_SLL;
            else                   d.illegal = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE)     d.sel = SEL_SRL;
            else if (funct7 == F7_ALT) d.sel = SEL_SRA;
            else                       d.illegal = 1'b1;
          end
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Present only when ALU_EXEC_MULDIV_EN is defined.
`ifdef ALU_EXEC_MULDIV_EN
module alu_iter_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_mul,
  input  logic            is_rem,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // acc: product accumulator (MUL) or partial remainder (DIV)
  // opd: shifted multiplicand (MUL) or divisor (DIV)
  // sh:  multiplier shifted right (MUL) or dividend/quotient shifted left (DIV)
  logic [XLEN-1:0]  acc, opd, sh;
  logic [CNT_W-1:0] cnt;
  logic             running, is_mul_q, is_rem_q;

  logic [XLEN:0]    rem_sh;
  logic [XLEN-1:0]  diff;
  logic             fits;

  always_comb begin
    rem_sh = {acc, sh[XLEN-1]};
    fits   = rem_sh >= {1'b0, opd};
    diff   = rem_sh[XLEN-1:0] - opd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      opd      <= '0;
      sh       <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      opd      <= is_mul ? op_a : op_b;
      sh       <= is_mul ? op_b : op_a;
      cnt      <= '0;
      running  <= 1'b1;
      done     <= 1'b0;
      is_mul_q <= is_mul;
      is_rem_q <= is_rem;
    end else if (running) begin
      if (is_mul_q) begin
        if (sh[0]) acc <= acc + opd;
        opd <= opd << 1;
        sh  <= sh >> 1;
      end else begin
        acc <= fits ? diff : rem_sh[XLEN-1:0];
        sh  <= {sh[XLEN-2:0], fits};
      end
      if (cnt == CNT_W'(XLEN - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign result = (is_mul_q || is_rem_q) ? acc : sh;

endmodule
`endif

// File: rtl/alu_exec_seq.sv
// Decoding ALU execute stage with valid/ready handshake on both sides.
// ALU_EXEC_MULDIV_EN enables the iterative MUL/DIVU/REMU path through BUSY.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_t               state_q, state_d;
  dec_t                 dec;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_res, result_q;
  logic                 illegal_q;
  logic                 accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign shamt     = op_b[SHAMT_W-1:0];

  always_comb dec = decode(alu_op, funct3, funct7);

  always_comb begin
    alu_res = '0;
    case (dec.sel)
      SEL_ADD:  alu_res = op_a + op_b;
      SEL_SUB:  alu_res = op_a - op_b;
      SEL_SLL:  alu_res = op_a << shamt;
      SEL_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      SEL_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      SEL_XOR:  alu_res = op_a ^ op_b;
      SEL_SRL:  alu_res = op_a >> shamt;
      SEL_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      SEL_OR:   alu_res = op_a | op_b;
      SEL_AND:  alu_res = op_a & op_b;
`ifdef ALU_EXEC_MULDIV_EN
      // Only the divide-by-zero shortcuts resolve here; the rest come from the engine.
      SEL_DIVU: alu_res = '1;
      SEL_REMU: alu_res = op_a;
`endif
      default:  alu_res = '0;
    endcase
    if (dec.illegal) alu_res = '0;
  end

`ifdef ALU_EXEC_MULDIV_EN
  logic            iterative, md_start, md_done;
  logic [XLEN-1:0] md_result;

  assign iterative = !dec.illegal &&
                     ((dec.sel == SEL_MUL) ||
                      ((dec.sel == SEL_DIVU || dec.sel == SEL_REMU) && op_b != '0));

  alu_iter_muldiv #(
    .XLEN  (XLEN),
    .CNT_W (SHAMT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_mul (dec.sel == SEL_MUL),
    .is_rem (dec.sel == SEL_REMU),
    .op_a   (op_a),
    .op_b   (op_b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  always_comb begin
    state_d = state_q;
`ifdef ALU_EXEC_MULDIV_EN
    md_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_EXEC_MULDIV_EN
          if (iterative) begin
            state_d  = BUSY;
            md_start = 1'b1;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ALU_EXEC_MULDIV_EN
      BUSY: if (md_done) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result_q  <= alu_res;
        illegal_q <= dec.illegal;
      end
`ifdef ALU_EXEC_MULDIV_EN
      if (state_q == BUSY && md_done) result_q <= md_result;
`endif
    end
  end

  assign result  = result_q;
  assign zero    = out_valid & (result_q == '0);
  assign illegal = out_valid & illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq at XLEN=32.
// Build with ALU_EXEC_MULDIV_EN defined to exercise the iterative engine.
module tb_alu_exec_seq;
  import alu_exec_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_exec_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill);
    check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    send(op, f3, f7, a, b);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
    check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    take();
    check({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  task automatic iter(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res);
    int n;
    send(ALUOP_R, f3, F7_MULDIV, a, b);
    check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd33);
    check({tag, ".result"}, result, exp_res);
    take();
  endtask

  initial begin
    int seen;
    logic [31:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = '0;
    funct3    = '0;
    funct7    = '0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    single("sub",      ALUOP_R,   3'b000, F7_ALT,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0);
    single("sra",      ALUOP_R,   3'b101, F7_ALT,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1'b0);
    single("add_wrap", ALUOP_R,   3'b000, F7_BASE, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0);
    single("xor",      ALUOP_R,   3'b100, F7_BASE, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1'b0);
    single("srl",      ALUOP_R,   3'b101, F7_BASE, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0);
    single("sltu_r",   ALUOP_R,   3'b011, F7_BASE, 32'd1,         32'd2,         32'd1,         1'b0, 1'b0);
    single("br_sltu",  ALUOP_BR,  3'b110, 7'h55,   32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0);
    single("br_slt",   ALUOP_BR,  3'b100, 7'h55,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0);
    single("br_ill",   ALUOP_BR,  3'b010, F7_BASE, 32'd3,         32'd4,         32'd0,         1'b1, 1'b1);
    single("i_sll_ill",ALUOP_I,   3'b001, F7_ALT,  32'd1,         32'd5,         32'd0,         1'b1, 1'b1);
    single("i_sll",    ALUOP_I,   3'b001, F7_BASE, 32'd1,         32'd5,         32'h20,        1'b0, 1'b0);
    single("i_slt",    ALUOP_I,   3'b010, 7'h7F,   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);
    single("mem_add",  ALUOP_MEM, 3'b111, 7'h7F,   32'h1000,      32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0);
    single("r_ill",    ALUOP_R,   3'b000, 7'b0000010, 32'd9,      32'd9,         32'd0,         1'b1, 1'b1);

    // Backpressure: result and in_ready must hold while out_ready stays low.
    send(ALUOP_R, 3'b111, F7_BASE, 32'h0000_F0F0, 32'h0000_FF00);
    held = 32'h0000_F000;
    check("bp.result0", result, held);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.result_hold", result, held);
      check("bp.in_ready_low", 32'(in_ready), 32'd0);
      check("bp.out_valid_hold", 32'(out_valid), 32'd1);
    end
    take();
    check("bp.in_ready_after", 32'(in_ready), 32'd1);
    check("bp.out_valid_after", 32'(out_valid), 32'd0);

`ifdef ALU_EXEC_MULDIV_EN
    iter("mul",  3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780);
    iter("divu", 3'b101, 32'd100,       32'd7,  32'd14);
    iter("remu", 3'b111, 32'd100,       32'd7,  32'd2);
    single("divu0", ALUOP_R, 3'b101, F7_MULDIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single("remu0", ALUOP_R, 3'b111, F7_MULDIV, 32'd5,    32'd0, 32'd5,         1'b0, 1'b0);
    single("md_ill", ALUOP_R, 3'b001, F7_MULDIV, 32'd5,   32'd3, 32'd0,         1'b1, 1'b1);

    // Reset in the middle of a division must abort it without any output.
    send(ALUOP_R, 3'b101, F7_MULDIV, 32'd1000, 32'd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.result", result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort.no_stale", 32'(seen), 32'd0);
`else
    single("mul_ill", ALUOP_R, 3'b000, F7_MULDIV, 32'h1234_5678, 32'h10, 32'd0, 1'b1, 1'b1);

    // Reset while a result is held discards it.
    send(ALUOP_R, 3'b110, F7_BASE, 32'h00F0, 32'h0F00);
    check("abort.result_pre", result, 32'h0FF0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.result", result, 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort.no_stale", 32'(seen), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
